axi_lite_interface: RTL and testbench
=====================================

Name: axi_lite_interface

Overview:
- AXI4-Lite slave front-end that converts AXI-Lite read/write transactions into a simple single-cycle register-bus strobe: address, enable, write-enable, write data, read data.
- Used by memory-mapped peripherals (e.g. the CLINT timer block) so that their register files only decode `address_o`/`en_o`/`we_o`.
- Handles one outstanding transaction at a time.
- Every response is OKAY.

Parameters:
- AXI_ADDR_WIDTH, 64: width of AR/AW address and `address_o`.
- AXI_DATA_WIDTH, 64: width of R/W data, `data_i` and `data_o`.
- AXI_ID_WIDTH, 10: kept for interface compatibility; unused, because AXI-Lite carries no IDs.
- lite_req_t, logic: request struct type. Fields: aw_valid, aw.addr, w_valid, w.data, w.strb, b_ready, ar_valid, ar.addr, r_ready.
- lite_resp_t, logic: response struct type. Fields: aw_ready, w_ready, b_valid, b.resp, ar_ready, r_valid, r.data, r.resp.

Ports:
- clk_i  input  1  clock; one clock for the whole block.
- rst_ni  input  1  reset; synchronous, active-low.
- axi_req_i  input  lite_req_t  AXI-Lite request channels.
- axi_resp_o  output  lite_resp_t  AXI-Lite response channels.
- address_o  output  AXI_ADDR_WIDTH  latched transaction address.
- en_o  output  1  register access strobe, one cycle per transaction.
- we_o  output  1  1 = write access, 0 = read access; only meaningful when `en_o` is 1.
- data_i  input  AXI_DATA_WIDTH  read data from the register file, sampled in the cycle `en_o` is 1 and `we_o` is 0.
- data_o  output  AXI_DATA_WIDTH  latched write data.

Behaviour:
- FSM states: IDLE, RD_ACC, RD_RESP, WR_ACC, WR_RESP. Registered: state, addr_q, wdata_q, rdata_q.
- Reset (`rst_ni` = 0 at a clk_i edge):
  - state = IDLE; addr_q, wdata_q, rdata_q = 0.
  - While `rst_ni` is low, all ready/valid outputs, `en_o` and `we_o` are forced to 0.
- IDLE:
  - `ar_ready` = 1.
  - `aw_ready` = `w_ready` = (`aw_valid` & `w_valid` & ~`ar_valid`).
  - AR handshake: addr_q <= ar.addr; go to RD_ACC.
  - Otherwise, AW and W both valid: accept both in the same cycle; addr_q <= aw.addr, wdata_q <= w.data; go to WR_ACC.
  - A write waits until both AW and W are valid. A lone AW or lone W is not accepted.
  - Reads take priority over writes when both are pending.
- RD_ACC:
  - `en_o` = 1, `we_o` = 0 for exactly one cycle.
  - rdata_q <= `data_i`; go to RD_RESP.
- RD_RESP:
  - `r_valid` = 1, r.data = rdata_q, r.resp = 2'b00 (OKAY).
  - Go to IDLE on `r_ready`. rdata_q is held stable while stalled.
- WR_ACC:
  - `en_o` = 1, `we_o` = 1, `data_o` = wdata_q for exactly one cycle; go to WR_RESP.
- WR_RESP:
  - `b_valid` = 1, b.resp = 2'b00; go to IDLE on `b_ready`.
- `address_o` = addr_q and `data_o` = wdata_q at all times. `en_o` = 0 outside the ACC states.
- Latency: handshake in cycle t, access strobe in t+1, response valid in t+2. The next request is accepted in the cycle after the response handshake at the earliest.
- All ready signals are 0 outside IDLE; requests are back-pressured.
- w.strb is ignored: a full-width write is always performed.
- No error responses are generated.
- Reset mid-transaction aborts it: no access strobe, no response.

Optional Feature:
- Macro AXI_LITE_IF_ASSERT_EN.
- When defined, simulation-only assertions are compiled in:
  - AXI_DATA_WIDTH must equal 64 (fatal at elaboration).
  - `r_valid` must not drop while `r_ready` = 0, and r.data must stay stable until the handshake.
  - `b_valid` must not drop while `b_ready` = 0.
  - `en_o` must never be high for two consecutive cycles.
- When undefined, no assertion code is present. RTL behaviour is identical either way.

Decomposition:
- Package axi_lite_interface_pkg: state enum (IDLE, RD_ACC, RD_RESP, WR_ACC, WR_RESP) and response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
- Single module; no sub-module is needed.

Test Plan:
- Reset held for 2 cycles, then released: all valid outputs 0, `en_o` = 0, `ar_ready` = 1 in the first IDLE cycle.
- Write aw.addr = 0x4000, w.data = 0xDEAD_BEEF_0000_0001 with AW and W valid together → `en_o` = 1, `we_o` = 1, `address_o` = 0x4000, `data_o` = that value for one cycle, then `b_valid` with resp 0.
- Read ar.addr = 0xBFF8 with `data_i` = 0x1234 during the strobe, `r_ready` held low 3 cycles → `r_valid` stays 1 and r.data stays 0x1234 throughout, until `r_ready`.
- AW valid alone for 4 cycles, W asserted later → no ready until both are valid, then a single write strobe.
- AR and AW+W valid in the same cycle → read is served first; the write is accepted after R completes.
- Reset asserted in WR_ACC → no B response; block returns to IDLE.

Source files
------------

// File: rtl/axi_lite_interface_pkg.sv
// Shared types for the AXI-Lite register front-end: FSM states, response codes
// and the default 64-bit AXI-Lite request/response channel structs.
package axi_lite_interface_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ACC,
        RD_RESP,
        WR_ACC,
        WR_RESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned LITE_ADDR_W = 64;
    localparam int unsigned LITE_DATA_W = 64;

    typedef struct packed {
        logic [LITE_ADDR_W-1:0] addr;
    } addr_chan_t;

    typedef struct packed {
        logic [LITE_DATA_W-1:0]   data;
        logic [LITE_DATA_W/8-1:0] strb;
    } w_chan_t;

    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [LITE_DATA_W-1:0] data;
        logic [1:0]             resp;
    } r_chan_t;

    typedef struct packed {
        logic       aw_valid;
        addr_chan_t aw;
        logic       w_valid;
        w_chan_t    w;
        logic       b_ready;
        logic       ar_valid;
        addr_chan_t ar;
        logic       r_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    ar_ready;
        logic    r_valid;
        r_chan_t r;
    } axi_lite_resp_t;

endpackage

// File: rtl/axi_lite_interface.sv
// AXI4-Lite slave that turns each read/write into a one-cycle register strobe.
// Define AXI_LITE_IF_ASSERT_EN to compile in simulation-only protocol assertions.
module axi_lite_interface
    import axi_lite_interface_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter type         lite_req_t     = axi_lite_req_t,
    parameter type         lite_resp_t    = axi_lite_resp_t
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  lite_req_t                 axi_req_i,
    output lite_resp_t                axi_resp_o,
    output logic [AXI_ADDR_WIDTH-1:0] address_o,
    output logic                      en_o,
    output logic                      we_o,
    input  logic [AXI_DATA_WIDTH-1:0] data_i,
    output logic [AXI_DATA_WIDTH-1:0] data_o
);

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      wr_go;
    logic                      unused_ok;

    // AXI-Lite has no IDs and writes are always full width
    assign unused_ok = (^axi_req_i.w.strb) | (AXI_ID_WIDTH == 0);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        axi_resp_o = '0;
        en_o       = 1'b0;
        we_o       = 1'b0;
        wr_go      = axi_req_i.aw_valid & axi_req_i.w_valid & ~axi_req_i.ar_valid;

        unique case (state_q)
            IDLE: begin
                axi_resp_o.ar_ready = 1'b1;
                axi_resp_o.aw_ready = wr_go;
                axi_resp_o.w_ready  = wr_go;
                if (axi_req_i.ar_valid) begin
                    addr_d  = axi_req_i.ar.addr;
                    state_d = RD_ACC;
                end else if (wr_go) begin
                    addr_d  = axi_req_i.aw.addr;
                    wdata_d = axi_req_i.w.data;
                    state_d = WR_ACC;
                end
            end
            RD_ACC: begin
                en_o    = 1'b1;
                rdata_d = data_i;
                state_d = RD_RESP;
            end
            RD_RESP: begin
                axi_resp_o.r_valid = 1'b1;
                if (axi_req_i.r_ready) state_d = IDLE;
            end
            WR_ACC: begin
                en_o    = 1'b1;
                we_o    = 1'b1;
                state_d = WR_RESP;
            end
            WR_RESP: begin
                axi_resp_o.b_valid = 1'b1;
                if (axi_req_i.b_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        axi_resp_o.r.data = rdata_q;
        axi_resp_o.r.resp = RESP_OKAY;
        axi_resp_o.b.resp = RESP_OKAY;

        // Handshake and strobe outputs stay quiet for the whole reset period
        if (!rst_ni) begin
            axi_resp_o.aw_ready = 1'b0;
            axi_resp_o.w_ready  = 1'b0;
            axi_resp_o.ar_ready = 1'b0;
            axi_resp_o.r_valid  = 1'b0;
            axi_resp_o.b_valid  = 1'b0;
            en_o                = 1'b0;
            we_o                = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign address_o = addr_q;
    assign data_o    = wdata_q;

`ifdef AXI_LITE_IF_ASSERT_EN
    if (AXI_DATA_WIDTH != 64) begin : g_width_check
        $fatal(1, "axi_lite_interface: AXI_DATA_WIDTH must be 64");
    end

    a_r_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        axi_resp_o.r_valid && !axi_req_i.r_ready |=> axi_resp_o.r_valid && $stable(axi_resp_o.r.data));

    a_b_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        axi_resp_o.b_valid && !axi_req_i.b_ready |=> axi_resp_o.b_valid);

    a_en_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
        en_o |=> !en_o);
`endif

endmodule

// File: tb/tb_axi_lite_interface.sv
// Scoreboard bench for axi_lite_interface: drivers push expected strobes and
// responses, a negedge monitor pops and compares whenever the DUT presents them.
module tb_axi_lite_interface;
    import axi_lite_interface_pkg::*;

    logic           clk = 1'b0;
    logic           rst_ni;
    axi_lite_req_t  req;
    axi_lite_resp_t resp;
    logic [63:0]    address_o;
    logic           en_o;
    logic           we_o;
    logic [63:0]    data_i;
    logic [63:0]    data_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] data;
        int          exp_cyc;
    } acc_t;

    acc_t        acc_q[$];
    logic [63:0] r_q[$];
    logic [1:0]  b_q[$];
    acc_t        mon_e;
    logic [63:0] mon_r;
    logic [1:0]  mon_b;

    axi_lite_interface #(
        .AXI_ADDR_WIDTH(64),
        .AXI_DATA_WIDTH(64),
        .AXI_ID_WIDTH  (10),
        .lite_req_t    (axi_lite_req_t),
        .lite_resp_t   (axi_lite_resp_t)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .axi_req_i (req),
        .axi_resp_o(resp),
        .address_o (address_o),
        .en_o      (en_o),
        .we_o      (we_o),
        .data_i    (data_i),
        .data_o    (data_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: strobes and response handshakes are compared in issue order
    always @(negedge clk) begin
        if (mon_en) begin
            if (en_o === 1'b1) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_strobe", en_o, 64'd0);
                end else begin
                    mon_e = acc_q.pop_front();
                    check("strobe_we", we_o, mon_e.we);
                    check("strobe_addr", address_o, mon_e.addr);
                    check("strobe_cycle", 64'(cyc), 64'(mon_e.exp_cyc));
                    if (mon_e.we) check("strobe_wdata", data_o, mon_e.data);
                end
            end
            if (resp.r_valid === 1'b1 && req.r_ready) begin
                if (r_q.size() == 0) begin
                    check("unexpected_r", resp.r_valid, 64'd0);
                end else begin
                    mon_r = r_q.pop_front();
                    check("r_data", resp.r.data, mon_r);
                    check("r_resp", resp.r.resp, RESP_OKAY);
                end
            end
            if (resp.b_valid === 1'b1 && req.b_ready) begin
                if (b_q.size() == 0) begin
                    check("unexpected_b", resp.b_valid, 64'd0);
                end else begin
                    mon_b = b_q.pop_front();
                    check("b_resp", resp.b.resp, mon_b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit rd, output int k);
        bit ok = 1'b0;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd ? resp.ar_ready : (resp.aw_ready && resp.w_ready)) begin
                ok = 1'b1;
                k  = cyc;
                break;
            end
        end
        check("ready_seen", ok, 64'd1);
    endtask

    task automatic wait_resp(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((resp.r_valid && req.r_ready) || (resp.b_valid && req.b_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 64'd1);
        tick();
    endtask

    task automatic push_acc(input logic we, input logic [63:0] a, input logic [63:0] d, input int c);
        acc_t e;
        e.we = we; e.addr = a; e.data = d; e.exp_cyc = c;
        acc_q.push_back(e);
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] d, input int w_delay);
        int k;
        req.aw_valid = 1'b1;
        req.aw.addr  = a;
        req.w.data   = d;
        req.w.strb   = '1;
        for (int i = 0; i < w_delay; i++) begin
            @(negedge clk);
            check("lone_aw_ready", resp.aw_ready, 64'd0);
            check("lone_w_ready", resp.w_ready, 64'd0);
            tick();
        end
        req.w_valid = 1'b1;
        wait_ready(1'b0, k);
        push_acc(1'b1, a, d, k + 1);
        b_q.push_back(RESP_OKAY);
        tick();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        wait_resp("b_handshake_seen");
    endtask

    task automatic do_read(input logic [63:0] a, input logic [63:0] rd, input int stall);
        int k;
        req.ar_valid = 1'b1;
        req.ar.addr  = a;
        req.r_ready  = (stall == 0);
        data_i       = rd;
        wait_ready(1'b1, k);
        push_acc(1'b0, a, 64'd0, k + 1);
        r_q.push_back(rd);
        tick();
        req.ar_valid = 1'b0;
        tick();
        // Register file data moves on after the strobe; the response must not
        data_i = ~rd;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_r_valid", resp.r_valid, 64'd1);
            check("stall_r_data", resp.r.data, rd);
            tick();
        end
        req.r_ready = 1'b1;
        wait_resp("r_handshake_seen");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_ni      = 1'b0;
        req         = '0;
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        data_i      = '0;

        @(negedge clk);
        check("rst_ar_ready_forced", resp.ar_ready, 64'd0);
        check("rst_en", en_o, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        check("idle_ar_ready", resp.ar_ready, 64'd1);
        check("idle_aw_ready", resp.aw_ready, 64'd0);
        check("idle_r_valid", resp.r_valid, 64'd0);
        check("idle_b_valid", resp.b_valid, 64'd0);
        check("idle_en", en_o, 64'd0);
        check("idle_address", address_o, 64'd0);
        check("idle_data_o", data_o, 64'd0);
        mon_en = 1'b1;
        tick();

        do_write(64'h4000, 64'hDEAD_BEEF_0000_0001, 0);
        do_read(64'hBFF8, 64'h1234, 3);
        do_write(64'h4008, 64'h1111_2222_3333_4444, 4);
        do_read(64'h0008, 64'h5555_AAAA_0F0F_F0F0, 0);

        // Read and write offered together: read first, write after R completes
        req.ar_valid = 1'b1;
        req.ar.addr  = 64'h10;
        data_i       = 64'hCAFE_F00D_0000_0042;
        req.aw_valid = 1'b1;
        req.aw.addr  = 64'h20;
        req.w_valid  = 1'b1;
        req.w.data   = 64'hA5A5_5A5A_C3C3_3C3C;
        wait_ready(1'b1, k);
        check("conc_aw_blocked", resp.aw_ready, 64'd0);
        push_acc(1'b0, 64'h10, 64'd0, k + 1);
        r_q.push_back(64'hCAFE_F00D_0000_0042);
        tick();
        req.ar_valid = 1'b0;
        @(negedge clk);
        check("busy_aw_ready", resp.aw_ready, 64'd0);
        check("busy_ar_ready", resp.ar_ready, 64'd0);
        tick();
        data_i = 64'd0;
        wait_resp("conc_r_seen");
        wait_ready(1'b0, k);
        push_acc(1'b1, 64'h20, 64'hA5A5_5A5A_C3C3_3C3C, k + 1);
        b_q.push_back(RESP_OKAY);
        tick();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        wait_resp("conc_b_seen");

        // Reset while in WR_ACC: no strobe, no B response
        req.aw_valid = 1'b1;
        req.aw.addr  = 64'h30;
        req.w_valid  = 1'b1;
        req.w.data   = 64'h0BAD_0BAD_0BAD_0BAD;
        wait_ready(1'b0, k);
        tick();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        rst_ni       = 1'b0;
        @(negedge clk);
        check("abort_en", en_o, 64'd0);
        check("abort_we", we_o, 64'd0);
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_b_valid", resp.b_valid, 64'd0);
            check("abort_ar_ready", resp.ar_ready, 64'd1);
            tick();
        end

        do_read(64'h0040, 64'h0000_0000_0000_0077, 1);

        repeat (3) tick();
        check("acc_q_drained", 64'(acc_q.size()), 64'd0);
        check("r_q_drained", 64'(r_q.size()), 64'd0);
        check("b_q_drained", 64'(b_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
